sha256_padder: RTL and testbench

Word-serial SHA-256 message padder that sits directly upstream of the SHA-256 compression core in the crypto accelerator user project. It accepts a message as a stream of 32-bit words with an end-of-message marker. It emits a stream of 512-bit blocks, one 32-bit word at a time, with FIPS 180-4 padding applied: a 0x80 byte, zero fill, and the 64-bit big-endian bit length. Downstream, the compression core consumes one word per handshake and starts a new compression on each `out_first`.

---
 rtl/sha256_padder.sv | 170 +++++++++++++++++
 tb/tb_sha256_padder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// Word-serial SHA-256 message padder: 32-bit message words in, padded 512-bit blocks out as words.
// Optional define SHA256_PADDER_BYTE_SWAP_EN byte-reverses in_data for little-endian producers.
module sha256_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_bytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_first,
  output logic        out_block_last,
  output logic        out_msg_last
);

  typedef enum logic [2:0] {StData, StMark, StZero, StLenHi, StLenLo} state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [LEN_W-4:0]  nbytes_q, nbytes_d;
  logic              valid_q, valid_d;
  logic [31:0]       word_q, word_d;
  logic              first_q, first_d;
  logic              blast_q, blast_d;
  logic              mlast_q, mlast_d;

  logic              load;
  logic [31:0]       din;
  logic [2:0]        kb;
  logic [31:0]       mark_word;
  logic [63:0]       len64;
  logic              emit;
  logic [31:0]       emit_word;
  logic              emit_mlast;

`ifdef SHA256_PADDER_BYTE_SWAP_EN
  assign din = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign din = in_data;
`endif

  assign load     = !valid_q || out_ready;
  // Gated by resetb so the input is refused while reset is held.
  assign in_ready = resetb && (state_q == StData) && load;

  assign kb = !in_last ? 3'd4 : ((in_bytes > 3'd4) ? 3'd4 : in_bytes);

  always_comb begin
    unique case (kb)
      3'd0:    mark_word = 32'h8000_0000;
      3'd1:    mark_word = {din[31:24], 24'h80_0000};
      3'd2:    mark_word = {din[31:16], 16'h8000};
      3'd3:    mark_word = {din[31:8], 8'h80};
      default: mark_word = din;
    endcase
  end

  always_comb begin
    len64 = '0;
    len64[LEN_W-1:0] = {nbytes_q, 3'b000};
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    nbytes_d   = nbytes_q;
    valid_d    = valid_q;
    word_d     = word_q;
    first_d    = first_q;
    blast_d    = blast_q;
    mlast_d    = mlast_q;
    emit       = 1'b0;
    emit_word  = 32'h0;
    emit_mlast = 1'b0;

    unique case (state_q)
      StData: begin
        if (in_valid && in_ready) begin
          emit     = 1'b1;
          nbytes_d = nbytes_q + (LEN_W-3)'(kb);
          if (!in_last) begin
            emit_word = din;
          end else if (kb == 3'd4) begin
            emit_word = din;
            state_d   = StMark;
          end else begin
            emit_word = mark_word;
            state_d   = (idx_q == 4'd13) ? StLenHi : StZero;
          end
        end
      end
      StMark: begin
        if (load) begin
          emit      = 1'b1;
          emit_word = 32'h8000_0000;
          state_d   = (idx_q == 4'd13) ? StLenHi : StZero;
        end
      end
      StZero: begin
        if (load) begin
          emit = 1'b1;
          if (idx_q == 4'd13) state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (load) begin
          emit      = 1'b1;
          emit_word = len64[63:32];
          state_d   = StLenLo;
        end
      end
      StLenLo: begin
        if (load) begin
          emit       = 1'b1;
          emit_word  = len64[31:0];
          emit_mlast = 1'b1;
          nbytes_d   = '0;
          state_d    = StData;
        end
      end
      default: state_d = StData;
    endcase

    // idx tracks the block position of the next word to enter the output register.
    if (load) begin
      valid_d = emit;
      if (emit) begin
        word_d  = emit_word;
        first_d = (idx_q == 4'd0);
        blast_d = (idx_q == 4'd15);
        mlast_d = emit_mlast;
        idx_d   = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= StData;
      idx_q    <= 4'd0;
      nbytes_q <= '0;
      valid_q  <= 1'b0;
      word_q   <= 32'h0;
      first_q  <= 1'b0;
      blast_q  <= 1'b0;
      mlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nbytes_q <= nbytes_d;
      valid_q  <= valid_d;
      word_q   <= word_d;
      first_q  <= first_d;
      blast_q  <= blast_d;
      mlast_q  <= mlast_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_word       = word_q;
  assign out_first      = first_q;
  assign out_block_last = blast_q;
  assign out_msg_last   = mlast_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: byte-level FIPS 180-4 padding model plus table and
// hand-written sequences (stalls, mid-block reset, back-to-back messages).
module tb_sha256_padder;

  logic        clock, resetb;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic [2:0]  in_bytes;
  logic        out_valid, out_ready, out_first, out_block_last, out_msg_last;
  logic [31:0] out_word;

  sha256_padder #(.LEN_W(64)) dut (
    .clock          (clock),
    .resetb         (resetb),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_bytes       (in_bytes),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_word       (out_word),
    .out_first      (out_first),
    .out_block_last (out_block_last),
    .out_msg_last   (out_msg_last)
  );

  typedef struct {
    int unsigned nbytes;
    int unsigned exp_words;
    logic [31:0] exp_len_lo;
  } vec_t;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned done_cnt = 0;
  int unsigned stall_pct = 0;
  int unsigned stall_err = 0;
  int unsigned stall_seen = 0;
  logic        abort = 1'b0;
  logic        prev_stall = 1'b0;
  logic [34:0] held = '0;
  logic [7:0]  msg_q[$];
  logic [34:0] exp_q[$];
  logic [34:0] got_q[$];
  logic [34:0] ref_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      out_ready = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
    end
  end

  // Records every handshake and checks that a stalled word stays put.
  initial begin
    forever begin
      @(negedge clock);
      if (!resetb) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && ({out_first, out_block_last, out_msg_last, out_word} !== held))
          stall_err++;
        if (out_valid && !out_ready) stall_seen++;
        prev_stall = out_valid && !out_ready;
        held = {out_first, out_block_last, out_msg_last, out_word};
        if (out_valid && out_ready) begin
          got_q.push_back({out_first, out_block_last, out_msg_last, out_word});
          if (out_msg_last) done_cnt++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic rand_msg(input int unsigned n);
    msg_q.delete();
    repeat (n) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length, cut into words.
  task automatic model_pad();
    logic [7:0]  p[$];
    logic [63:0] bl;
    int unsigned nw;
    p  = msg_q;
    bl = 64'(msg_q.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int j = 7; j >= 0; j--) p.push_back(bl[8*j +: 8]);
    nw = p.size() / 4;
    exp_q.delete();
    for (int i = 0; i < int'(nw); i++)
      exp_q.push_back({(i % 16) == 0, (i % 16) == 15, i == int'(nw) - 1,
                       p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
  endtask

  // Call aligned to posedge+1. Unused bytes and in_bytes on non-last words are randomised.
  task automatic send_msg();
    int unsigned n, nw, k, cyc;
    logic [31:0] d;
    logic [7:0]  b;
    logic        acc;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int unsigned w = 0; w < nw; w++) begin
      for (int j = 0; j < 4; j++) begin
        b = (4*w + j < n) ? msg_q[4*w + j] : 8'($urandom);
`ifdef SHA256_PADDER_BYTE_SWAP_EN
        d[8*j +: 8] = b;
`else
        d[31-8*j -: 8] = b;
`endif
      end
      k        = (n == 0) ? 0 : n - 4*w;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = (w == nw - 1);
      if (w == nw - 1) in_bytes = (k == 4) ? 3'($urandom_range(4, 7)) : 3'(k);
      else             in_bytes = 3'($urandom_range(0, 7));
      acc = 1'b0;
      cyc = 0;
      while (!acc) begin
        @(negedge clock);
        acc = in_ready;
        @(posedge clock);
        #1;
        if (abort) begin
          in_valid = 1'b0;
          return;
        end
        cyc++;
        if (cyc > 2000) begin
          n_total++;
          $display("FAIL drv_timeout: word %0d not accepted after %0d cycles", w, cyc);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned target);
    int unsigned c = 0;
    while (done_cnt < target && c < 5000) begin
      @(negedge clock);
      c++;
    end
    if (done_cnt < target) begin
      n_total++;
      $display("FAIL %s timeout: messages done %0d want %0d", name, done_cnt, target);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic compare_to(input string name, input logic [34:0] e[$]);
    check({name, " count"}, 64'(got_q.size()), 64'(e.size()));
    for (int i = 0; i < e.size() && i < got_q.size(); i++)
      check($sformatf("%s w%0d", name, i), 64'(got_q[i]), 64'(e[i]));
  endtask

  task automatic run_msg(input string name);
    got_q.delete();
    done_cnt = 0;
    model_pad();
    @(posedge clock);
    #1;
    send_msg();
    wait_done(name, 1);
    compare_to(name, exp_q);
  endtask

  // "abc" as one word, also checking one-cycle input-to-output latency.
  task automatic abc_seq(input string name);
    msg_q = '{8'h61, 8'h62, 8'h63};
    model_pad();
    got_q.delete();
    done_cnt = 0;
    in_valid = 1'b1;
`ifdef SHA256_PADDER_BYTE_SWAP_EN
    in_data  = 32'h0063_6261;
`else
    in_data  = 32'h6162_6300;
`endif
    in_last  = 1'b1;
    in_bytes = 3'd3;
    @(negedge clock);
    check({name, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(negedge clock);
    check({name, " latency valid"}, 64'(out_valid), 64'd1);
    check({name, " word0"}, 64'(out_word), 64'h6162_6380);
    check({name, " first"}, 64'(out_first), 64'd1);
    wait_done(name, 1);
    compare_to(name, exp_q);
    check({name, " len word"}, 64'(got_q[15]), {29'd0, 3'b011, 32'h18});
  endtask

  vec_t        vecs[11];
  logic [34:0] e1[$];
  logic [7:0]  m1[$];
  logic [7:0]  m2[$];

  initial begin
    vecs[0]  = '{0,   16, 32'h0};
    vecs[1]  = '{1,   16, 32'h8};
    vecs[2]  = '{3,   16, 32'h18};
    vecs[3]  = '{52,  16, 32'h1A0};
    vecs[4]  = '{55,  16, 32'h1B8};
    vecs[5]  = '{56,  32, 32'h1C0};
    vecs[6]  = '{60,  32, 32'h1E0};
    vecs[7]  = '{63,  32, 32'h1F8};
    vecs[8]  = '{64,  32, 32'h200};
    vecs[9]  = '{119, 32, 32'h3B8};
    vecs[10] = '{120, 48, 32'h3C0};

    resetb   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    in_bytes = '0;
    repeat (3) @(negedge clock);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_word", 64'(out_word), 64'd0);
    check("rst flags", 64'({out_first, out_block_last, out_msg_last}), 64'd0);
    @(posedge clock);
    #1;
    resetb = 1'b1;
    @(negedge clock);
    check("post-rst in_ready", 64'(in_ready), 64'd1);
    check("post-rst out_valid", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;

    abc_seq("abc");

    for (int i = 0; i < 11; i++) begin
      stall_pct = (i % 2 == 1) ? 30 : 0;
      rand_msg(vecs[i].nbytes);
      run_msg($sformatf("vec%0d", vecs[i].nbytes));
      check($sformatf("vec%0d words", vecs[i].nbytes), 64'(got_q.size()), 64'(vecs[i].exp_words));
      check($sformatf("vec%0d len", vecs[i].nbytes), 64'(got_q[got_q.size()-1]),
            {29'd0, 3'b011, vecs[i].exp_len_lo});
    end

    // Two messages with no gap: the second must follow straight after the first's length word.
    stall_pct = 0;
    rand_msg(20);
    m1 = msg_q;
    model_pad();
    e1 = exp_q;
    rand_msg(7);
    m2 = msg_q;
    model_pad();
    foreach (exp_q[i]) e1.push_back(exp_q[i]);
    got_q.delete();
    done_cnt = 0;
    @(posedge clock);
    #1;
    msg_q = m1;
    send_msg();
    msg_q = m2;
    send_msg();
    wait_done("b2b", 2);
    compare_to("b2b", e1);

    // Three-block message, first without stalls, then with ~50% output stalls.
    rand_msg(130);
    run_msg("nostall");
    ref_q      = got_q;
    stall_pct  = 50;
    stall_err  = 0;
    stall_seen = 0;
    run_msg("stall");
    compare_to("stall vs nostall", ref_q);
    check("stall hold", 64'(stall_err), 64'd0);
    check("stall seen", 64'(stall_seen != 0), 64'd1);
    stall_pct = 0;

    // Reset mid-block, then a clean "abc".
    rand_msg(130);
    got_q.delete();
    done_cnt = 0;
    @(posedge clock);
    #1;
    fork
      send_msg();
    join_none
    for (int c = 0; c < 200 && got_q.size() < 7; c++) @(negedge clock);
    check("rst idx7 reached", 64'(got_q.size() >= 7), 64'd1);
    @(posedge clock);
    #2;
    resetb = 1'b0;
    abort  = 1'b1;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst out_word", 64'(out_word), 64'd0);
    check("midrst flags", 64'({out_first, out_block_last, out_msg_last}), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd0);
    wait fork;
    abort = 1'b0;
    @(posedge clock);
    #1;
    resetb = 1'b1;
    got_q.delete();
    @(posedge clock);
    #1;
    abc_seq("abc after rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
